multi_sync_edge_det: RTL and testbench
======================================

MULTI_SYNC_EDGE_DET -- requirements
Module: multi_sync_edge_det

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: number of independent input channels, legal range 1..32.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchroniser flop depth per channel, legal range 2..4.
REQ-003 The block SHALL have parameter FILTER_LEN, default 1: consecutive stable cycles required before a level change is accepted, legal range 1..255.
REQ-004 The block SHALL have parameter EDGE_MODE, default 0: 0 = rising edge, 1 = falling edge, 2 = both edges.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port sig_i, input, WIDTH bits: asynchronous level inputs, one per channel.
REQ-008 The block SHALL have port clr_i, input, WIDTH bits: per-channel clear of the sticky event flag, synchronous to clk.
REQ-009 The block SHALL have port level_o, output, WIDTH bits: the filtered, synchronised level of each channel.
REQ-010 The block SHALL have port edge_o, output, WIDTH bits: a one-cycle pulse on each qualifying edge of level_o.
REQ-011 The block SHALL have port evt_o, output, WIDTH bits: a sticky flag per channel, set by edge_o.
REQ-012 An out-of-range parameter value SHALL cause an elaboration error; it SHALL NOT be clamped silently.

Function
REQ-013 Each channel SHALL pass sig_i[i] through a SYNC_STAGES-deep flop chain; s[i] denotes the last stage.
REQ-014 Each channel SHALL hold a filtered level lvl[i] (driven on level_o[i]) and a counter cnt[i] of width clog2(FILTER_LEN+1).
REQ-015 When s[i] == lvl[i], cnt[i] SHALL be 0 on the next cycle.
REQ-016 When s[i] != lvl[i] and cnt[i] < FILTER_LEN-1, cnt[i] SHALL increment.
REQ-017 When s[i] != lvl[i] and cnt[i] == FILTER_LEN-1, lvl[i] SHALL take s[i] and cnt[i] SHALL return to 0 in the same edge.
REQ-018 Latency: a stable change on sig_i[i] SHALL appear on level_o[i] exactly SYNC_STAGES+FILTER_LEN clock edges after the first edge that samples the change.
REQ-019 A deviation on s[i] lasting fewer than FILTER_LEN cycles SHALL leave lvl[i] unchanged, and cnt[i] SHALL restart from 0 on the next deviation.
REQ-020 edge_o[i] SHALL be registered and asserted for exactly one cycle, in the same cycle that level_o[i] takes its new value, when the transition matches EDGE_MODE.
REQ-021 The matching transitions SHALL be 0->1 for EDGE_MODE 0, 1->0 for EDGE_MODE 1, and either direction for EDGE_MODE 2.
REQ-022 Back-to-back accepted transitions (FILTER_LEN=1 with input toggling) SHALL each produce their own edge_o pulse; no pulse SHALL be merged or dropped.
REQ-023 evt_o[i] SHALL be set in the cycle after edge_o[i]=1.
REQ-024 evt_o[i] SHALL be cleared in the cycle after clr_i[i]=1.
REQ-025 If edge_o[i]=1 and clr_i[i]=1 in the same cycle, the set SHALL win and evt_o[i] SHALL be 1 on the next cycle.
REQ-026 Channels SHALL be fully independent, with no cross-channel interaction.

Reset
REQ-027 While rst=1 at a clock edge, all synchroniser flops, lvl, cnt, edge_o and evt_o SHALL become 0.
REQ-028 A reset asserted mid-filter SHALL discard the partial count.
REQ-029 If sig_i[i]=1 on reset release, level_o[i] SHALL rise after the normal latency and produce a rising-edge event (in EDGE_MODE 0 or 2).
REQ-030 Outputs SHALL be undefined only before the first clock edge with rst=1.

Verification (WIDTH=4, SYNC_STAGES=2, FILTER_LEN=3, EDGE_MODE=2 unless stated)
REQ-031 Scenario: sig_i 0000->0001, held -> level_o[0]=1 and edge_o=0001 for one cycle, 5 edges after the first sampling edge; evt_o=0001 on the next cycle.
REQ-032 Scenario: 2-cycle-wide high glitch on sig_i[1] -> level_o, edge_o and evt_o stay 0000.
REQ-033 Scenario: EDGE_MODE=0, sig_i[2] 0->1 held, then 1->0 held -> exactly one edge_o[2] pulse, on the rise only; level_o[2] follows both transitions.
REQ-034 Scenario: clr_i[0]=1 in the same cycle as an edge_o[0] pulse -> evt_o[0]=1; clr_i[0]=1 one cycle later -> evt_o[0]=0.
REQ-035 Scenario: rst=1 for one cycle while cnt[3]=2 and evt_o=1111 -> all outputs 0000 on the next cycle; with sig_i[3]=1 held, a fresh edge_o[3] pulse occurs 5 edges after release.
REQ-036 Scenario: FILTER_LEN=1, sig_i[0] toggling every 4 cycles -> every toggle produces one edge_o[0] pulse, 3 edges after its first sampling edge.

Source files
------------

// File: rtl/multi_sync_edge_det.sv
// multi_sync_edge_det
//
// Purpose:
//   WIDTH independent channels. Each channel synchronises an asynchronous
//   level input, debounces it with a stability filter, flags qualifying
//   edges of the filtered level with a one-cycle pulse, and keeps a sticky
//   per-channel event flag until it is cleared.
//
// Parameters:
//   WIDTH       - number of channels (1..32)
//   SYNC_STAGES - synchroniser depth per channel (2..4)
//   FILTER_LEN  - consecutive differing cycles needed to accept a change (1..255)
//   EDGE_MODE   - 0 = rising, 1 = falling, 2 = both
//
// Ports:
//   clk     - single clock, all flops rising-edge
//   rst     - synchronous, active-high reset
//   sig_i   - asynchronous level inputs, one per channel
//   clr_i   - per-channel clear of the sticky event flag
//   level_o - filtered, synchronised level per channel
//   edge_o  - one-cycle pulse, coincident with level_o taking a matching new value
//   evt_o   - sticky event flag per channel, set the cycle after edge_o
//
// There is no handshake on this block: every output is a registered level
// or single-cycle pulse, valid every cycle after the first reset edge.

module multi_sync_edge_det #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 1,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] edge_o,
    output logic [WIDTH-1:0] evt_o
);

    // Illegal parameter values stop elaboration instead of being clamped.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("multi_sync_edge_det: WIDTH=%0d outside 1..32", WIDTH);
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("multi_sync_edge_det: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
        end
        if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_bad_filter
            $error("multi_sync_edge_det: FILTER_LEN=%0d outside 1..255", FILTER_LEN);
        end
        if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
            $error("multi_sync_edge_det: EDGE_MODE=%0d outside 0..2", EDGE_MODE);
        end
    endgenerate

    localparam int             CW       = $clog2(FILTER_LEN + 1);
    // Count value on which a still-differing sample is accepted.
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    // ------------------------------------------------------------------
    // Synchroniser chain, stage 0 samples the asynchronous input.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= sig_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Stability filter and edge qualification.
    // ------------------------------------------------------------------
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [WIDTH-1:0] lvl_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] evt_q;

    logic [WIDTH-1:0] differs;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] match;

    always_comb begin
        differs = sync_s ^ lvl_q;
        accept  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = differs[i] && (cnt_q[i] == CNT_LAST);
        end
        // An accepted change moves lvl to sync_s, so sync_s gives the direction.
        rise = accept & sync_s;
        fall = accept & ~sync_s;
        case (EDGE_MODE)
            0:       match = rise;
            1:       match = fall;
            default: match = rise | fall;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            lvl_q  <= '0;
            edge_q <= '0;
            evt_q  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                // Any agreeing sample restarts the count; so does acceptance.
                if (!differs[i] || accept[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
            lvl_q  <= lvl_q ^ accept;
            edge_q <= match;
            // Set has priority over clear when both arrive together.
            evt_q  <= edge_q | (evt_q & ~clr_i);
        end
    end

    assign level_o = lvl_q;
    assign edge_o  = edge_q;
    assign evt_o   = evt_q;

endmodule

// File: tb/tb_multi_sync_edge_det.sv
// tb_multi_sync_edge_det
//
// Three instances with WIDTH=4, SYNC_STAGES=2:
//   dut 0 : FILTER_LEN=3, EDGE_MODE=2
//   dut 1 : FILTER_LEN=3, EDGE_MODE=0
//   dut 2 : FILTER_LEN=1, EDGE_MODE=2
// Inputs change 2 time units after a rising edge; "cycle N" means the
// interval after the N-th rising edge. A change driven in cycle P is first
// sampled by edge P+1 and reaches level_o in cycle P+SYNC_STAGES+FILTER_LEN.
// The driver schedules expected outputs per cycle; the monitor checks them
// on the falling edge and flags any edge_o pulse nobody scheduled.

module tb_multi_sync_edge_det;

    localparam int W = 4;
    localparam int NDUT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] sig     [NDUT];
    logic [W-1:0] clr     [NDUT];
    logic [W-1:0] level_w [NDUT];
    logic [W-1:0] pulse_w [NDUT];
    logic [W-1:0] evt_w   [NDUT];

    multi_sync_edge_det #(.WIDTH(W), .SYNC_STAGES(2), .FILTER_LEN(3), .EDGE_MODE(2)) dut_both (
        .clk(clk), .rst(rst), .sig_i(sig[0]), .clr_i(clr[0]),
        .level_o(level_w[0]), .edge_o(pulse_w[0]), .evt_o(evt_w[0])
    );

    multi_sync_edge_det #(.WIDTH(W), .SYNC_STAGES(2), .FILTER_LEN(3), .EDGE_MODE(0)) dut_rise (
        .clk(clk), .rst(rst), .sig_i(sig[1]), .clr_i(clr[1]),
        .level_o(level_w[1]), .edge_o(pulse_w[1]), .evt_o(evt_w[1])
    );

    multi_sync_edge_det #(.WIDTH(W), .SYNC_STAGES(2), .FILTER_LEN(1), .EDGE_MODE(2)) dut_fast (
        .clk(clk), .rst(rst), .sig_i(sig[2]), .clr_i(clr[2]),
        .level_o(level_w[2]), .edge_o(pulse_w[2]), .evt_o(evt_w[2])
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int           dut;
        int           cyc;
        logic [W-1:0] pulse;
        logic [W-1:0] level;
        logic [W-1:0] evt;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic cmp(input string name, input int d, input logic [W-1:0] act,
                       input logic [W-1:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s dut%0d cycle %0d: got %b, expected %b", name, d, cyc, act, exp_v);
        end
    endtask

    // Keep the queue ordered by cycle so the monitor only looks at the head.
    task automatic expect_at(input int d, input int c, input logic [W-1:0] p,
                             input logic [W-1:0] lv, input logic [W-1:0] ev);
        exp_t e;
        int   i;
        e.dut   = d;
        e.cyc   = c;
        e.pulse = p;
        e.level = lv;
        e.evt   = ev;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
        exp_q.insert(i, e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t       e;
        logic [2:0] seen;
        seen = '0;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc != cyc) begin
                tests_run++;
                tests_failed++;
                $display("FAIL stale_check dut%0d: scheduled cycle %0d, now %0d", e.dut, e.cyc, cyc);
            end else begin
                seen[e.dut] = 1'b1;
                cmp("edge_o",  e.dut, pulse_w[e.dut], e.pulse);
                cmp("level_o", e.dut, level_w[e.dut], e.level);
                cmp("evt_o",   e.dut, evt_w[e.dut],   e.evt);
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            if (!seen[d] && pulse_w[d] !== '0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_edge dut%0d cycle %0d: got %b, expected 0000", d, cyc, pulse_w[d]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int p;
        int q;
        logic [W-1:0] lv;

        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            sig[d] = '0;
            clr[d] = '0;
        end
        tick(2);
        // Reset state while rst is still high at edge 3.
        for (int d = 0; d < NDUT; d++) expect_at(d, cyc + 1, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Single rising change on channel 0: 5-cycle latency, evt one later.
        p = cyc;
        sig[0] = 4'b0001;
        expect_at(0, p + 4, 4'b0000, 4'b0000, 4'b0000);
        expect_at(0, p + 5, 4'b0001, 4'b0001, 4'b0000);
        expect_at(0, p + 6, 4'b0000, 4'b0001, 4'b0001);
        tick(8);

        // Two-cycle glitch on channel 1 must be filtered out.
        p = cyc;
        sig[0] = 4'b0011;
        tick(2);
        sig[0] = 4'b0001;
        expect_at(0, p + 5, 4'b0000, 4'b0001, 4'b0001);
        expect_at(0, p + 8, 4'b0000, 4'b0001, 4'b0001);
        tick(8);

        // Clear, then clear coinciding with a pulse (set wins), then clear alone.
        p = cyc;
        clr[0] = 4'b0001;
        expect_at(0, p + 1, 4'b0000, 4'b0001, 4'b0000);
        tick(1);
        clr[0] = 4'b0000;
        q = cyc;
        sig[0] = 4'b0000;
        expect_at(0, q + 4, 4'b0000, 4'b0001, 4'b0000);
        expect_at(0, q + 5, 4'b0001, 4'b0000, 4'b0000);
        tick(5);
        clr[0] = 4'b0001;
        expect_at(0, q + 6, 4'b0000, 4'b0000, 4'b0001);
        tick(1);
        expect_at(0, q + 7, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        clr[0] = 4'b0000;
        tick(3);

        // All channels up and down, then reset while cnt[3]=2.
        p = cyc;
        sig[0] = 4'b1111;
        expect_at(0, p + 5, 4'b1111, 4'b1111, 4'b0000);
        expect_at(0, p + 6, 4'b0000, 4'b1111, 4'b1111);
        tick(6);
        sig[0] = 4'b0000;
        expect_at(0, p + 11, 4'b1111, 4'b0000, 4'b1111);
        tick(6);
        sig[0] = 4'b1000;
        tick(4);
        expect_at(0, p + 16, 4'b0000, 4'b0000, 4'b1111);
        rst = 1'b1;
        expect_at(0, p + 17, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        rst = 1'b0;
        // First edge after release samples sig; pulse 5 edges later.
        expect_at(0, p + 21, 4'b0000, 4'b0000, 4'b0000);
        expect_at(0, p + 22, 4'b1000, 4'b1000, 4'b0000);
        expect_at(0, p + 23, 4'b0000, 4'b1000, 4'b1000);
        tick(8);

        // Rising-only mode: level follows both ways, one pulse only.
        p = cyc;
        sig[1] = 4'b0100;
        expect_at(1, p + 4, 4'b0000, 4'b0000, 4'b0000);
        expect_at(1, p + 5, 4'b0100, 4'b0100, 4'b0000);
        expect_at(1, p + 6, 4'b0000, 4'b0100, 4'b0100);
        tick(8);
        p = cyc;
        sig[1] = 4'b0000;
        expect_at(1, p + 4, 4'b0000, 4'b0100, 4'b0100);
        expect_at(1, p + 5, 4'b0000, 4'b0000, 4'b0100);
        expect_at(1, p + 6, 4'b0000, 4'b0000, 4'b0100);
        tick(8);

        // FILTER_LEN=1: toggle every 4 cycles, each toggle gives a pulse 3 later.
        for (int k = 0; k < 4; k++) begin
            lv = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            sig[2] = lv;
            expect_at(2, cyc + 3, 4'b0001, lv, (k == 0) ? 4'b0000 : 4'b0001);
            expect_at(2, cyc + 4, 4'b0000, lv, 4'b0001);
            tick(4);
        end

        // FILTER_LEN=1: toggle every cycle, pulses back to back, none merged.
        p = cyc;
        for (int k = 0; k < 4; k++) begin
            lv = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            sig[2] = lv;
            expect_at(2, cyc + 3, 4'b0001, lv, 4'b0001);
            tick(1);
        end
        expect_at(2, p + 7, 4'b0000, 4'b0000, 4'b0001);
        tick(10);

        // Anything still queued was never reached.
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            tests_failed++;
            $display("FAIL unchecked dut%0d: scheduled cycle %0d, ended at %0d", e.dut, e.cyc, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
